// File: rtl/click_conditioner.sv
// click_conditioner
// Turns four raw, bouncy, asynchronous player buttons into the clicks[3:0]
// pulse vector used by the game core. Each button gets its own channel:
//   btn_raw -> 2-flop synchronizer -> debounce FSM -> accept gate -> counter.
// A confirmed press gives one press event. The event is accepted when
// enable=1 and the (possibly just-cleared) count is below max_clicks.
// An accepted event pulses clicks[i] for one cycle and increments count i.
// Counts saturate at max_clicks.
//
// Optional feature: define CLICK_CONDITIONER_STUCK_DETECT_EN to flag
// buttons that stay pressed for STUCK_CYCLES cycles. A stuck channel
// accepts no presses until it returns to IDLE.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw[3:0] raw button levels, asynchronous to clk
//   enable       when low, presses are tracked but not counted or pulsed
//   clear_counts synchronous clear of all click counters
//   max_clicks   per-player click limit (shared)
//   clicks[3:0]  registered single-cycle click pulses
//   click_count  four 4-bit counts, player i at [4i+3:4i]
//   limit_hit    bit i set when count i >= max_clicks (combinational)
//   stuck        bit i set while button i is flagged stuck (0 without the feature)
module click_conditioner #(
  parameter int DEBOUNCE = 4
`ifdef CLICK_CONDITIONER_STUCK_DETECT_EN
  , parameter int STUCK_CYCLES = 1000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic        enable,
  input  logic        clear_counts,
  input  logic [3:0]  max_clicks,
  output logic [3:0]  clicks,
  output logic [15:0] click_count,
  output logic [3:0]  limit_hit,
  output logic [3:0]  stuck
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST = DEBOUNCE[7:0];

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [1:0] sync_r;
    logic       s;
    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       press_s;
    logic       to_idle_s;
    logic [3:0] count_r;
    logic [3:0] base_s;
    logic       accept_s;
    logic       click_r;
    logic       stuck_s;

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= 2'b00;
      end else begin
        sync_r <= {sync_r[0], btn_raw[i]};
      end
    end

    assign s = sync_r[1];

    // Debounce FSM state and stability counter registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r <= IDLE;
        cnt_r   <= 8'd0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
      end
    end

    // Debounce FSM next state; press_s marks the confirming edge
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      press_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (s) begin
            state_s = PRESS_WAIT;
            cnt_s   = 8'd1;
          end else begin
            state_s = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_s = IDLE;
          end else if (cnt_r == DEB_LAST) begin
            state_s = PRESSED;
            press_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_s = RELEASE_WAIT;
            cnt_s   = 8'd1;
          end else begin
            state_s = PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_s = PRESSED;
          end else if (cnt_r == DEB_LAST) begin
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end
      endcase
    end

    assign to_idle_s = (state_s == IDLE) && (state_r != IDLE);

    // Clear takes effect before the press is judged against the limit
    always_comb begin
      base_s   = 4'd0;
      accept_s = 1'b0;
      if (clear_counts) begin
        base_s = 4'd0;
      end else begin
        base_s = count_r;
      end
      if (press_s && enable && !stuck_s && (base_s < max_clicks)) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end

    // Click pulse and saturating counter; base_s < max_clicks prevents wrap
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_r <= 4'd0;
        click_r <= 1'b0;
      end else begin
        count_r <= accept_s ? (base_s + 4'd1) : base_s;
        click_r <= accept_s;
      end
    end

`ifdef CLICK_CONDITIONER_STUCK_DETECT_EN
    localparam logic [15:0] STUCK_LAST = STUCK_CYCLES[15:0];
    logic [15:0] held_r;
    logic        stuck_r;

    // Held-time counter; flag rises on the cycle the count reaches the limit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        held_r  <= 16'd0;
        stuck_r <= 1'b0;
      end else if (to_idle_s) begin
        held_r  <= 16'd0;
        stuck_r <= 1'b0;
      end else if (((state_r == PRESSED) || (state_r == RELEASE_WAIT)) &&
                   (held_r != STUCK_LAST)) begin
        held_r <= held_r + 16'd1;
        if ((held_r + 16'd1) == STUCK_LAST) begin
          stuck_r <= 1'b1;
        end else begin
          stuck_r <= stuck_r;
        end
      end else begin
        held_r  <= held_r;
        stuck_r <= stuck_r;
      end
    end

    assign stuck_s = stuck_r;
`else
    assign stuck_s = 1'b0;
`endif

    assign clicks[i]            = click_r;
    assign click_count[4*i +: 4] = count_r;
    assign limit_hit[i]         = (count_r >= max_clicks);
    assign stuck[i]             = stuck_s;
  end

endmodule
